// File: rtl/udp_csum_pkg.sv
// Shared types and constants for the UDP checksum read-side scheduler.
// Build option UDP_CSUM_ZERO_MAP_EN is consumed in udp_checksum_sched.
package udp_csum_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ACC_W          = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUM   = 3'd1,
        FOLD1 = 3'd2,
        FOLD2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Indexed by the byte tail of the datagram; entry 0 keeps the whole word.
    localparam logic [3:0][31:0] TAIL_MASK = {
        32'hFFFFFF00,
        32'hFFFF0000,
        32'hFF000000,
        32'hFFFFFFFF
    };

    function automatic logic [ACC_W-1:0] fold16(input logic [ACC_W-1:0] a);
        return {16'h0000, a[15:0]} + {16'h0000, a[31:16]};
    endfunction

endpackage

// File: rtl/udp_csum_word_add.sv
// Combinational adder: folds one big-endian 32-bit FIFO word (optionally
// tail-masked) into the running 32-bit ones'-complement accumulator.
module udp_csum_word_add
    import udp_csum_pkg::*;
(
    input  logic [31:0]      word_i,
    input  logic             mask_en_i,
    input  logic [1:0]       tail_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] sum_o
);

    logic [31:0] mask;
    logic [31:0] masked;

    always_comb begin
        mask   = mask_en_i ? TAIL_MASK[tail_i] : 32'hFFFFFFFF;
        masked = word_i & mask;
        sum_o  = acc_i + {16'h0000, masked[31:16]} + {16'h0000, masked[15:0]};
    end

endmodule

// File: rtl/udp_checksum_sched.sv
// Pops one datagram's words from the checksum prefetch FIFO and returns the UDP
// checksum. Define UDP_CSUM_ZERO_MAP_EN to transmit a zero checksum as 16'hFFFF.
module udp_checksum_sched
    import udp_csum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [15:0]       cmd_pseudo_sum,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    output logic              fifo_rd_en,
    output logic              csum_vld,
    input  logic              csum_rdy,
    output logic [15:0]       csum,
    output logic [2:0]        dbg_state_o
);

    localparam int WL_W = LEN_W - 1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WL_W-1:0]  words_left_q, words_left_d;
    logic [1:0]       tail_q, tail_d;
    logic [15:0]      csum_q, csum_d;
    logic             csum_vld_q, csum_vld_d;

    logic [LEN_W:0]   len_round;
    logic [WL_W-1:0]  cmd_words;
    logic             pop;
    logic [ACC_W-1:0] add_sum;
    logic [ACC_W-1:0] fold_acc;
    logic [15:0]      raw_csum;
    logic [15:0]      out_csum;

    assign len_round = {1'b0, cmd_len} + (LEN_W+1)'(BYTES_PER_WORD - 1);
    assign cmd_words = len_round[LEN_W:2];
    assign pop       = (state_q == SUM) && fifo_rd_vld;
    assign fold_acc  = fold16(acc_q);
    assign raw_csum  = ~fold_acc[15:0];

`ifdef UDP_CSUM_ZERO_MAP_EN
    assign out_csum = (raw_csum == 16'h0000) ? 16'hFFFF : raw_csum;
`else
    assign out_csum = raw_csum;
`endif

    udp_csum_word_add u_word_add (
        .word_i    (fifo_rd_data[31:0]),
        .mask_en_i (words_left_q == WL_W'(1)),
        .tail_i    (tail_q),
        .acc_i     (acc_q),
        .sum_o     (add_sum)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            words_left_q <= '0;
            tail_q       <= '0;
            csum_q       <= '0;
            csum_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            words_left_q <= words_left_d;
            tail_q       <= tail_d;
            csum_q       <= csum_d;
            csum_vld_q   <= csum_vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        words_left_d = words_left_q;
        tail_d       = tail_q;
        csum_d       = csum_q;
        csum_vld_d   = csum_vld_q;
        case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    acc_d        = {16'h0000, cmd_pseudo_sum};
                    words_left_d = cmd_words;
                    tail_d       = cmd_len[1:0];
                    state_d      = (cmd_words != '0) ? SUM : FOLD1;
                end
            end
            SUM: begin
                if (pop) begin
                    acc_d        = add_sum;
                    words_left_d = words_left_q - WL_W'(1);
                    if (words_left_q == WL_W'(1)) begin
                        state_d = FOLD1;
                    end
                end
            end
            FOLD1: begin
                acc_d   = fold_acc;
                state_d = FOLD2;
            end
            FOLD2: begin
                // The result register is loaded here so csum is valid the
                // same cycle csum_vld rises in DONE.
                acc_d      = fold_acc;
                csum_d     = out_csum;
                csum_vld_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (csum_rdy) begin
                    csum_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_rdy     = (state_q == IDLE);
    assign fifo_rd_en  = (state_q == SUM);
    assign csum_vld    = csum_vld_q;
    assign csum        = csum_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_udp_checksum_sched.sv
// Bench for udp_checksum_sched: vector table, stall/backpressure and reset
// sequences, randomized datagrams checked against a byte-level reference.
module tb_udp_checksum_sched;
    import udp_csum_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [15:0] cmd_len;
    logic [15:0] cmd_pseudo_sum;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_vld;
    logic        fifo_rd_en;
    logic        csum_vld;
    logic        csum_rdy;
    logic [15:0] csum;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    udp_checksum_sched #(.DATA_W(32), .LEN_W(16)) dut (
        .rd_clk         (clk),
        .rd_rst         (rst),
        .cmd_vld        (cmd_vld),
        .cmd_rdy        (cmd_rdy),
        .cmd_len        (cmd_len),
        .cmd_pseudo_sum (cmd_pseudo_sum),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_vld    (fifo_rd_vld),
        .fifo_rd_en     (fifo_rd_en),
        .csum_vld       (csum_vld),
        .csum_rdy       (csum_rdy),
        .csum           (csum),
        .dbg_state_o    (dbg_state)
    );

    // Show-ahead FIFO model: always has data (garbage beyond the datagram),
    // so any over-pop shows up in the pop count.
    logic [31:0] mem [4096];
    int          rd_ptr  = 0;
    int          pop_cnt = 0;
    logic        vld_gate;

    assign fifo_rd_vld  = vld_gate;
    assign fifo_rd_data = mem[rd_ptr[11:0]];

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_rd_vld) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

`ifdef UDP_CSUM_ZERO_MAP_EN
    localparam logic [15:0] ZM_EXP = 16'hFFFF;
`else
    localparam logic [15:0] ZM_EXP = 16'h0000;
`endif

    logic [15:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0]      len;
        logic [15:0]      pseudo;
        logic [3:0][31:0] w;
        logic [15:0]      exp;
        int               lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent byte-wise ones'-complement sum over the datagram bytes.
    function automatic logic [15:0] ref_csum(input int len, input logic [15:0] pseudo, input int base);
        int unsigned s;
        logic [31:0] w;
        int unsigned b;
        logic [15:0] r;
        s = pseudo;
        for (int i = 0; i < len; i++) begin
            w = mem[(base + i / 4) % 4096];
            b = (w >> (8 * (3 - (i % 4)))) & 32'hFF;
            s += ((i % 2) == 0) ? (b << 8) : b;
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        r = ~s[15:0];
`ifdef UDP_CSUM_ZERO_MAP_EN
        if (r == 16'h0000) r = 16'hFFFF;
`endif
        return r;
    endfunction

    // Called #1 after an active edge with the DUT idle.
    task automatic do_cmd(input string name, input logic [15:0] len, input logic [15:0] pseudo,
                          input int stall_after, input int stall_cnt, input int hold,
                          input int exp_lat, input logic [15:0] exp_csum);
        int          nw;
        int          start_pop;
        int          cyc;
        int          stalled;
        logic [15:0] held;
        logic [15:0] exp_v;
        bit          stable;
        nw        = (int'(len) + 3) / 4;
        start_pop = pop_cnt;
        stalled   = 0;
        exp_q.push_back(exp_csum);
        check({name, "_rdy_idle"}, cmd_rdy, 1);
        cmd_vld        = 1'b1;
        cmd_len        = len;
        cmd_pseudo_sum = pseudo;
        @(posedge clk); #1;
        cmd_vld        = 1'b0;
        cmd_len        = 16'($urandom);
        cmd_pseudo_sum = 16'($urandom);
        cyc = 1;
        check({name, "_rdy_busy"}, cmd_rdy, 0);
        while (!csum_vld && cyc < 300) begin
            vld_gate = !(((pop_cnt - start_pop) == stall_after) && (stalled < stall_cnt));
            if (!vld_gate) stalled++;
            @(posedge clk); #1;
            cyc++;
        end
        vld_gate = 1'b1;
        if (!csum_vld) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no csum_vld after %0d cycles expected cycle %0d", name, cyc, exp_lat);
            exp_v = exp_q.pop_front();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        check({name, "_lat"}, cyc, exp_lat);
        held   = csum;
        stable = 1'b1;
        repeat (hold) begin
            if (csum !== held || csum_vld !== 1'b1 || cmd_rdy !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        if (hold > 0) check({name, "_hold"}, {31'd0, stable}, 1);
        csum_rdy = 1'b1;
        exp_v = exp_q.pop_front();
        check({name, "_csum"}, csum, exp_v);
        @(posedge clk); #1;
        csum_rdy = 1'b0;
        check({name, "_post"}, {cmd_rdy, csum_vld}, 2'b10);
        check({name, "_pops"}, pop_cnt - start_pop, nw);
    endtask

    task automatic place_words(input int n, input logic [3:0][31:0] w);
        for (int k = 0; k < n; k++) mem[(rd_ptr + k) % 4096] = w[k];
    endtask

    initial begin
        int start_pop;
        int bound;
        logic [15:0] p;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        rst = 1'b1;
        cmd_vld = 1'b0;
        cmd_len = '0;
        cmd_pseudo_sum = '0;
        csum_rdy = 1'b0;
        vld_gate = 1'b1;

        vecs[0] = '{16'd4,  16'h0000, {32'h0, 32'h0, 32'h0, 32'h12345678}, 16'h9753, 4};
        vecs[1] = '{16'd1,  16'h0000, {32'h0, 32'h0, 32'h0, 32'hABCDEF01}, 16'h54FF, 4};
        vecs[2] = '{16'd4,  16'h0001, {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF}, 16'hFFFE, 4};
        vecs[3] = '{16'd0,  16'hFFFF, {32'h0, 32'h0, 32'h0, 32'h0},        ZM_EXP,   3};
        vecs[4] = '{16'd8,  16'h0000, {32'h0, 32'h0, 32'h00030004, 32'h00010002}, 16'hFFF5, 5};
        vecs[5] = '{16'd2,  16'h1234, {32'h0, 32'h0, 32'h0, 32'hABCD9999}, 16'h41FE, 4};
        vecs[6] = '{16'd3,  16'h0000, {32'h0, 32'h0, 32'h0, 32'h11223344}, 16'hBBDD, 4};
        vecs[7] = '{16'd7,  16'h0000, {32'h0, 32'h0, 32'h05060799, 32'h01020304}, 16'hEFF3, 5};
        vecs[8] = '{16'd16, 16'h8000, {32'h80008000, 32'h80008000, 32'h80008000, 32'h80008000}, 16'h7FFB, 7};

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_csum_vld", csum_vld, 0);
        check("rst_csum", csum, 16'h0000);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            place_words((int'(vecs[i].len) + 3) / 4, vecs[i].w);
            do_cmd($sformatf("vec%0d", i), vecs[i].len, vecs[i].pseudo, -1, 0, 0,
                   vecs[i].lat, vecs[i].exp);
        end

        // Stall after the first word plus result backpressure.
        p = 16'($urandom);
        do_cmd("stall", 16'd12, p, 1, 3, 5, 9, ref_csum(12, p, rd_ptr));

        // Reset in the middle of SUM, then a fresh datagram on the remaining words.
        start_pop = pop_cnt;
        cmd_vld = 1'b1;
        cmd_len = 16'd40;
        cmd_pseudo_sum = 16'($urandom);
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        bound = 0;
        while ((pop_cnt - start_pop) < 4 && bound < 50) begin
            @(posedge clk); #1;
            bound++;
        end
        check("mid_pops", pop_cnt - start_pop, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_rdy", cmd_rdy, 1);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_csum_vld", csum_vld, 0);
        check("mid_rst_csum", csum, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_pop", pop_cnt - start_pop, 4);
        p = 16'($urandom);
        do_cmd("after_rst", 16'd24, p, -1, 0, 0, 9, ref_csum(24, p, rd_ptr));

        for (int t = 0; t < 20; t++) begin
            int len;
            int nw;
            int sa;
            int sc;
            int hold;
            len  = $urandom_range(0, 64);
            nw   = (len + 3) / 4;
            sa   = $urandom_range(0, nw);
            sc   = $urandom_range(0, 3);
            hold = $urandom_range(0, 3);
            p    = 16'($urandom);
            do_cmd($sformatf("rnd%0d", t), 16'(len), p, sa, sc, hold,
                   nw + 3 + ((sa < nw) ? sc : 0), ref_csum(len, p, rd_ptr));
        end

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
